// File: rtl/alu_seq.sv
// W-bit ALU: 16 opcodes, single-cycle logic/arith plus shift-add multiply and restoring divide.
// Latency: 1 cycle for single-cycle ops, W cycles (accept to out_valid register) for multiply/divide.
// Backpressure: in_ready drops while a multiply/divide iterates; in_valid is ignored until IDLE.
module alu_seq #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] R,
  input  logic [W-1:0] S,
  input  logic [3:0]   Alu_Op,
  output logic         out_valid,
  output logic [W-1:0] Y,
  output logic [W-1:0] Y_hi,
  output logic         N,
  output logic         Z,
  output logic         C,
  output logic         V
);

  localparam int CW = $clog2(W + 1);

  localparam logic [3:0] OP_MUL = 4'hD;
  localparam logic [3:0] OP_DIV = 4'hE;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t         state, state_nxt;
  logic           ready_q;
  logic           accept;
  logic [CW-1:0]  cnt;
  logic [W-1:0]   opa;      // multiplicand (MUL) or divisor (DIV)
  logic [W-1:0]   acc_hi;   // partial product high half / partial remainder
  logic [W-1:0]   acc_lo;   // multiplier being consumed / dividend shifting into quotient
  logic           dz_q;     // divisor was zero at accept

  // single-cycle datapath
  logic [W-1:0]   add_a, add_b;
  logic           add_cin, is_add;
  logic [W:0]     add_sum;
  logic [W-1:0]   sc_y;
  logic           sc_c, sc_v;

  // iteration step datapath
  logic [W:0]     mul_sum;
  logic [W-1:0]   mul_hi_nxt, mul_lo_nxt;
  logic [W:0]     div_shift;
  logic [W+1:0]   div_diff;
  logic           div_ok;
  logic [W-1:0]   div_hi_nxt, div_lo_nxt;

  // result load
  logic           last_iter;
  logic           ld_en;
  logic [W-1:0]   ld_y, ld_hi;
  logic           ld_c, ld_v;
  logic           start_mul, start_div;

  // ready is registered so it reads 0 for the whole reset period
  assign in_ready = ready_q;
  assign accept   = in_valid & ready_q;

  // single-cycle result, carry and overflow for every non-iterative opcode
  always_comb begin
    add_a   = '0;
    add_b   = '0;
    add_cin = 1'b0;
    is_add  = 1'b0;
    sc_y    = '0;
    sc_c    = 1'b0;
    sc_v    = 1'b0;
    case (Alu_Op)
      4'h0: sc_y = S;
      4'h1: sc_y = R;
      4'h2: begin add_a = S;  add_b = '0; add_cin = 1'b1; is_add = 1'b1; end
      4'h3: begin add_a = S;  add_b = '1; add_cin = 1'b0; is_add = 1'b1; end
      4'h4: begin add_a = R;  add_b = S;  add_cin = 1'b0; is_add = 1'b1; end
      4'h5: begin add_a = R;  add_b = ~S; add_cin = 1'b1; is_add = 1'b1; end
      4'h6: begin sc_y = {1'b0, S[W-1:1]}; sc_c = S[0]; end
      4'h7: begin sc_y = {S[W-2:0], 1'b0}; sc_c = S[W-1]; end
      4'h8: sc_y = R & S;
      4'h9: sc_y = R | S;
      4'hA: sc_y = R ^ S;
      4'hB: sc_y = ~S;
      4'hC: begin add_a = ~S; add_b = '0; add_cin = 1'b1; is_add = 1'b1; end
      4'hF: begin sc_y = {S[W-1], S[W-1:1]}; sc_c = S[0]; end
      default: sc_y = '0;
    endcase
    add_sum = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_cin};
    if (is_add) begin
      sc_y = add_sum[W-1:0];
      sc_c = add_sum[W];
      sc_v = (add_a[W-1] == add_b[W-1]) && (add_sum[W-1] != add_a[W-1]);
    end
  end

  // one shift-add step and one restoring-divide step per clock
  always_comb begin
    mul_sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opa} : {(W+1){1'b0}});
    mul_hi_nxt = mul_sum[W:1];
    mul_lo_nxt = {mul_sum[0], acc_lo[W-1:1]};
    div_shift  = {acc_hi, acc_lo[W-1]};
    // extra guard bit so the borrow is unambiguous even for a zero divisor
    div_diff   = {1'b0, div_shift} - {2'b00, opa};
    div_ok     = ~div_diff[W+1];
    div_hi_nxt = div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
    div_lo_nxt = {acc_lo[W-2:0], div_ok};
  end

  // next state and which result (if any) is registered this edge
  always_comb begin
    state_nxt = state;
    last_iter = (cnt == CW'(1));
    ld_en     = 1'b0;
    ld_y      = '0;
    ld_hi     = '0;
    ld_c      = 1'b0;
    ld_v      = 1'b0;
    start_mul = 1'b0;
    start_div = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (Alu_Op == OP_MUL) begin
            start_mul = 1'b1;
            state_nxt = MUL;
          end else if (Alu_Op == OP_DIV) begin
            start_div = 1'b1;
            state_nxt = DIV;
          end else begin
            ld_en = 1'b1;
            ld_y  = sc_y;
            ld_c  = sc_c;
            ld_v  = sc_v;
          end
        end
      end
      MUL: begin
        if (last_iter) begin
          state_nxt = IDLE;
          ld_en     = 1'b1;
          ld_y      = mul_lo_nxt;
          ld_hi     = mul_hi_nxt;
          ld_c      = (mul_hi_nxt != '0);
        end
      end
      DIV: begin
        if (last_iter) begin
          state_nxt = IDLE;
          ld_en     = 1'b1;
          ld_y      = div_lo_nxt;
          ld_hi     = div_hi_nxt;
          ld_c      = dz_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state register; ready mirrors the IDLE state one edge after reset release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= state_nxt;
      ready_q <= (state_nxt == IDLE);
    end
  end

  // operand latch, iteration registers and counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      opa    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      cnt    <= '0;
      dz_q   <= 1'b0;
    end else if (start_mul) begin
      opa    <= R;
      acc_hi <= '0;
      acc_lo <= S;
      cnt    <= CW'(W);
      dz_q   <= 1'b0;
    end else if (start_div) begin
      opa    <= S;
      acc_hi <= '0;
      acc_lo <= R;
      cnt    <= CW'(W);
      dz_q   <= (S == '0);
    end else if (state == MUL) begin
      acc_hi <= mul_hi_nxt;
      acc_lo <= mul_lo_nxt;
      cnt    <= cnt - CW'(1);
    end else if (state == DIV) begin
      acc_hi <= div_hi_nxt;
      acc_lo <= div_lo_nxt;
      cnt    <= cnt - CW'(1);
    end
  end

  // registered results and flags; hold until the next result, strobe out_valid once
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      Y         <= '0;
      Y_hi      <= '0;
      N         <= 1'b0;
      Z         <= 1'b0;
      C         <= 1'b0;
      V         <= 1'b0;
    end else begin
      out_valid <= ld_en;
      if (ld_en) begin
        Y    <= ld_y;
        Y_hi <= ld_hi;
        N    <= ld_y[W-1];
        Z    <= (ld_y == '0);
        C    <= ld_c;
        V    <= ld_v;
      end
    end
  end

endmodule
